// File: rtl/seq_mul.sv
// Sequential shift-add multiplier with button-driven operand loads.
// Signed operands are multiplied as magnitudes; the sign is applied when the product is latched.
module seq_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     sw,
    input  logic [2:0]           btn,
    input  logic                 signed_mode,
    output logic [2*WIDTH-1:0]   res,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    res_q, res_d;
    logic             done_q, done_d;
    logic [PW-1:0]    acc_sum;

    // Absolute value in signed mode; -2^(W-1) maps to 2^(W-1), which still fits W unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return WIDTH'(~v + WIDTH'(1));
        end
        return v;
    endfunction

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        done_d   = 1'b0;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        unique case (state_q)
            S_IDLE: begin
                if (btn[0]) op1_d = sw;
                if (btn[1]) op2_d = sw;
                // Start captures the pre-edge operands, so a same-cycle load only affects later runs.
                if (btn[2]) begin
                    mcand_d  = PW'(magnitude(op1_q, signed_mode));
                    mplier_d = magnitude(op2_q, signed_mode);
                    neg_d    = signed_mode & (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    res_d   = neg_q ? PW'(~acc_sum + PW'(1)) : acc_sum;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            done_q   <= done_d;
        end
    end

    assign res  = res_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: countdown/arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then randomized button traffic.
module tb_seq_mul;

    localparam int unsigned W = 8;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   sw;
    logic [2:0]     btn;
    logic           signed_mode;
    logic [2*W-1:0] res;
    logic           busy;
    logic           done;

    int checks;
    int failures;

    seq_mul #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .btn         (btn),
        .signed_mode (signed_mode),
        .res         (res),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] product(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        longint p;
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        p = sa * sb;
        return p[2*W-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: remaining busy cycles after a start, product computed arithmetically.
    int             m_rem;
    logic [W-1:0]   m_op1, m_op2;
    logic [2*W-1:0] m_res, m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_op1  <= '0;
            m_op2  <= '0;
            m_res  <= '0;
            m_pend <= '0;
        end else if (m_rem == 0) begin
            if (btn[2]) begin
                m_pend <= product(m_op1, m_op2, signed_mode);
                m_rem  <= W + 1;
            end
            if (btn[0]) m_op1 <= sw;
            if (btn[1]) m_op2 <= sw;
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) m_res <= m_pend;
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_rem != 0));
        chk("done", 64'(done), 64'(m_rem == 1));
        chk("res",  64'(res),  64'(m_res));
    end

    task automatic load(input logic [1:0] which, input logic [W-1:0] val);
        @(negedge clk);
        sw  = val;
        btn = {1'b0, which};
        @(negedge clk);
        btn = 3'b000;
    endtask

    task automatic start(input logic mode);
        @(negedge clk);
        signed_mode = mode;
        btn = 3'b100;
        @(negedge clk);
        btn = 3'b000;
    endtask

    // Waits for done (bounded); returns busy cycles seen up to and including done.
    task automatic wait_done(input string name, output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = (busy === 1'b1) ? 1 : 0;
        if (done === 1'b1) seen = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nbusy = nbusy + 1;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
    endtask

    task automatic run_expect(input string name, input logic mode, input logic [2*W-1:0] exp);
        int nb;
        start(mode);
        wait_done(name, nb);
        chk(name, 64'(res), 64'(exp));
        @(negedge clk);
    endtask

    initial begin
        int nb;
        int dcount;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        sw          = '0;
        btn         = 3'b000;
        signed_mode = 1'b0;

        // Pin the model arithmetic itself.
        chk("model_ffxff",  64'(product(8'hFF, 8'hFF, 1'b0)), 64'h0000_FE01);
        chk("model_80x80s", 64'(product(8'h80, 8'h80, 1'b1)), 64'h0000_4000);
        chk("model_fdx05s", 64'(product(8'hFD, 8'h05, 1'b1)), 64'h0000_FFF1);

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res",  64'(res),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: unsigned 0xFF*0xFF with busy length.
        load(2'b11, 8'hFF);
        start(1'b0);
        wait_done("s1", nb);
        chk("s1_busy_cycles", 64'(nb), 64'd9);
        chk("s1_res", 64'(res), 64'hFE01);
        @(negedge clk);
        chk("s1_busy_after", 64'(busy), 64'd0);

        // Scenario 2: most-negative squared, signed then unsigned.
        load(2'b11, 8'h80);
        run_expect("s2_signed", 1'b1, 16'h4000);
        run_expect("s2_unsigned", 1'b0, 16'h4000);

        // Scenario 3: -3*5, then zero operand.
        load(2'b01, 8'hFD);
        load(2'b10, 8'h05);
        run_expect("s3_neg", 1'b1, 16'hFFF1);
        load(2'b01, 8'h00);
        start(1'b1);
        wait_done("s3_zero", nb);
        chk("s3_zero_cycles", 64'(nb), 64'd9);
        chk("s3_zero_res", 64'(res), 64'h0000);
        @(negedge clk);

        // Scenario 4: start/load pulses during RUN are ignored; mode flip too.
        load(2'b01, 8'hFD);
        start(1'b1);
        @(negedge clk);
        sw = 8'h11;
        btn = 3'b101;
        signed_mode = 1'b0;
        @(negedge clk);
        btn = 3'b000;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("s4_done_pulses", 64'(dcount), 64'd1);
        chk("s4_res", 64'(res), 64'hFFF1);
        run_expect("s4_op1_kept", 1'b1, 16'hFFF1);

        // Scenario 5: load in the start cycle uses old op1 now, new op1 later.
        load(2'b01, 8'h02);
        load(2'b10, 8'h03);
        @(negedge clk);
        signed_mode = 1'b0;
        sw  = 8'h07;
        btn = 3'b101;
        @(negedge clk);
        btn = 3'b000;
        wait_done("s5a", nb);
        chk("s5a_res", 64'(res), 64'h0006);
        @(negedge clk);
        run_expect("s5b", 1'b0, 16'h0015);

        // Scenario 6: asynchronous reset four cycles into RUN.
        load(2'b11, 8'h0F);
        start(1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_busy", 64'(busy), 64'd0);
        chk("s6_done", 64'(done), 64'd0);
        chk("s6_res",  64'(res),  64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("s6_no_done", 64'(dcount), 64'd0);

        // Randomized traffic; the per-cycle compare covers everything.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            sw          = W'($urandom);
            btn         = 3'($urandom_range(0, 7)) & {($urandom_range(0, 3) == 0), 2'b11};
            signed_mode = 1'($urandom);
        end
        @(negedge clk);
        btn = 3'b000;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_mul.md
SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port sw, input, WIDTH bits, operand data bus.
REQ-005 SHALL have port btn, input, 3 bits: btn[0] load op1, btn[1] load op2, btn[2] start.
REQ-006 SHALL have port signed_mode, input, 1 bit: 1 means two's-complement operands, 0 means unsigned operands.
REQ-007 SHALL have port res, output, 2*WIDTH bits, registered product.
REQ-008 SHALL have port busy, output, 1 bit, high while a multiplication is in progress.
REQ-009 SHALL have port done, output, 1 bit, one-cycle pulse when res updates.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-011 In IDLE, btn[0] high SHALL load op1 from sw, and btn[1] high SHALL load op2 from sw.
- Both buttons high in the same cycle load sw into both registers.
REQ-012 In RUN and DONE, btn[0] and btn[1] SHALL be ignored; op1 and op2 hold their values.
REQ-013 In IDLE, btn[2] high SHALL:
- copy op1, op2 and signed_mode into working registers;
- clear the accumulator;
- move the FSM to RUN.
REQ-014 When a load and start occur in the same IDLE cycle, the multiplication SHALL use the pre-edge op1/op2 values; the load still takes effect for later operations.
REQ-015 btn[2] in RUN or DONE SHALL be ignored, with no queuing.
REQ-016 RUN SHALL last exactly WIDTH cycles.
- Each cycle performs one shift-add step on the operand magnitudes.
- The FSM then moves to DONE.
REQ-017 In signed mode, working operands SHALL be the absolute values.
- The result sign is op1[WIDTH-1] XOR op2[WIDTH-1].
- On entry to DONE, the magnitude product is negated when the sign is 1.
REQ-018 res SHALL be the exact product with no overflow.
- Signed mode: 2*WIDTH-bit two's complement; -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2) is represented correctly.
- Unsigned mode: the 2*WIDTH-bit unsigned product.
REQ-019 res SHALL update only on the edge entering DONE and SHALL hold until the next DONE.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-021 Timing SHALL be as follows, with the start edge at cycle t:
- busy = 1 for cycles t+1 .. t+WIDTH+1 (RUN plus DONE);
- done = 1 in cycle t+WIDTH+1;
- the next start is accepted at edge t+WIDTH+2.
REQ-022 busy SHALL be 0 in IDLE and 1 in RUN and DONE, decoded directly from state registers.
REQ-023 A zero operand SHALL still take the full WIDTH-cycle latency and SHALL give res = 0.
REQ-024 A change of signed_mode during RUN SHALL have no effect on the result in progress.

Reset
REQ-025 rst_n low SHALL immediately, without waiting for clk, force:
- state = IDLE;
- op1 = op2 = 0, working registers = 0;
- res = 0, busy = 0, done = 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation, and no done pulse SHALL follow reset release.
REQ-027 After rst_n rises, the first rising clk edge SHALL be treated as a normal IDLE cycle.

Verification (WIDTH=8)
REQ-028 Scenario 1: unsigned, load 0xFF into op1 and op2, then start.
- busy is high for 9 cycles.
- done pulses 9 cycles after start; res = 0xFE01.
REQ-029 Scenario 2: signed, op1 = 0x80, op2 = 0x80, then start.
- res = 0x4000.
- Repeat in unsigned mode: res = 0x4000.
REQ-030 Scenario 3: signed, op1 = 0xFD (-3), op2 = 0x05, then start.
- res = 0xFFF1.
- Then op1 = 0x00: res = 0x0000 after the full 9 cycles.
REQ-031 Scenario 4: during RUN, pulse btn[2] and btn[0] with sw = 0x11.
- The result is unchanged.
- op1 is unchanged.
- Exactly one done pulse occurs.
REQ-032 Scenario 5: start with op1 = 0x02, op2 = 0x03, and load btn[0] with sw = 0x07 in the same cycle.
- res = 0x0006.
- A following start gives res = 0x0015.
REQ-033 Scenario 6: assert rst_n low 4 cycles into RUN, asynchronously between clock edges.
- busy, done and res drop to 0 before the next edge.
- No done pulse follows reset release.
